// File: rtl/pc_branch_unit_pkg.sv
// Shared processor package: PC width, reset vector default and the PC FSM state.
package pc_branch_unit_pkg;

  localparam int unsigned PC_W   = 32;
  localparam int unsigned JIDX_W = 26;

  localparam logic [PC_W-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_REDIR = 1'b1
  } pc_state_e;

endpackage

// File: rtl/pc_branch_unit_target_calc.sv
// Combinational redirect target computation for branches and jumps.
module pc_target_calc
  import pc_branch_unit_pkg::*;
(
  input  logic [PC_W-1:0]   pc_plus4,
  input  logic [PC_W-1:0]   branch_pc,
  input  logic [PC_W-1:0]   branch_offset,
  input  logic [JIDX_W-1:0] jump_index,
  output logic [PC_W-1:0]   branch_target,
  output logic [PC_W-1:0]   jump_target
);

  logic [PC_W-1:0] offset_bytes;

  // Word offset to byte offset; sum wraps modulo 2^32.
  always_comb begin
    offset_bytes  = branch_offset << 2;
    branch_target = branch_pc + offset_bytes;
    jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
  end

endmodule

// File: rtl/pc_branch_unit.sv
// PC register, redirect FSM and pipeline flush generation.
// Optional macro BRANCH_DELAY_SLOT_EN: branch/jump delay slot executes, so no
// flushes are raised; the REDIR state is still entered.
module pc_branch_unit
  import pc_branch_unit_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic              Clk_in,
  input  logic              Reset_in,
  input  logic              Stall_in,
  input  logic              BranchValid_in,
  input  logic              Branch_in,
  input  logic [PC_W-1:0]   BranchPC_in,
  input  logic [PC_W-1:0]   BranchOffset_in,
  input  logic              Jump_in,
  input  logic [JIDX_W-1:0] JumpTarget_in,
  output logic [PC_W-1:0]   PC_out,
  output logic [PC_W-1:0]   PCPlus4_out,
  output logic              FlushIF_out,
  output logic              FlushID_out,
  output logic              Misalign_out
);

  pc_state_e       state;
  logic [PC_W-1:0] branch_target;
  logic [PC_W-1:0] jump_target;
  logic            branch_taken;
  logic            jump_taken;
  logic            redirect;
  logic [PC_W-1:0] redirect_target;
  logic [PC_W-1:0] pc_next;

  assign PCPlus4_out = PC_out + 32'd4;

  pc_target_calc u_target_calc (
    .pc_plus4      (PCPlus4_out),
    .branch_pc     (BranchPC_in),
    .branch_offset (BranchOffset_in),
    .jump_index    (JumpTarget_in),
    .branch_target (branch_target),
    .jump_target   (jump_target)
  );

  // Redirect decode; in REDIR the branch/jump inputs belong to squashed bubbles.
  always_comb begin
    branch_taken    = BranchValid_in && Branch_in && (state == ST_RUN);
    jump_taken      = Jump_in && (state == ST_RUN) && !branch_taken;
    redirect        = branch_taken || jump_taken;
    redirect_target = branch_taken ? branch_target : jump_target;
    if (redirect)      pc_next = redirect_target;
    else if (Stall_in) pc_next = PC_out;
    else               pc_next = PCPlus4_out;
  end

  // PC register, FSM state and sticky misalignment flag.
  always_ff @(posedge Clk_in or posedge Reset_in) begin
    if (Reset_in) begin
      PC_out       <= RESET_VECTOR;
      state        <= ST_RUN;
      Misalign_out <= 1'b0;
    end else begin
      PC_out       <= pc_next;
      state        <= redirect ? ST_REDIR : ST_RUN;
      Misalign_out <= Misalign_out || (redirect && (redirect_target[1:0] != 2'b00));
    end
  end

  // Flushes are combinational and forced low during reset.
`ifdef BRANCH_DELAY_SLOT_EN
  assign FlushIF_out = 1'b0;
  assign FlushID_out = 1'b0;
`else
  assign FlushIF_out = !Reset_in && redirect;
  assign FlushID_out = !Reset_in && branch_taken;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed, table-driven bench for pc_branch_unit (RESET_VECTOR = 0).
module tb_pc_branch_unit;

`ifdef BRANCH_DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        Clk_in = 1'b0;
  logic        Reset_in;
  logic        Stall_in, BranchValid_in, Branch_in, Jump_in;
  logic [31:0] BranchPC_in, BranchOffset_in;
  logic [25:0] JumpTarget_in;
  logic [31:0] PC_out, PCPlus4_out;
  logic        FlushIF_out, FlushID_out, Misalign_out;

  int checks   = 0;
  int failures = 0;

  pc_branch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
    .Clk_in          (Clk_in),
    .Reset_in        (Reset_in),
    .Stall_in        (Stall_in),
    .BranchValid_in  (BranchValid_in),
    .Branch_in       (Branch_in),
    .BranchPC_in     (BranchPC_in),
    .BranchOffset_in (BranchOffset_in),
    .Jump_in         (Jump_in),
    .JumpTarget_in   (JumpTarget_in),
    .PC_out          (PC_out),
    .PCPlus4_out     (PCPlus4_out),
    .FlushIF_out     (FlushIF_out),
    .FlushID_out     (FlushID_out),
    .Misalign_out    (Misalign_out)
  );

  always #5 Clk_in = ~Clk_in;

  typedef struct {
    logic        stall;
    logic        bv;
    logic        br;
    logic [31:0] bpc;
    logic [31:0] boff;
    logic        jmp;
    logic [25:0] jt;
    logic        fif;   // expected FlushIF before the edge (no delay slot)
    logic        fid;   // expected FlushID before the edge (no delay slot)
    logic [31:0] pc;    // expected PC after the edge
    logic        mis;   // expected Misalign after the edge
  } vec_t;

  localparam int NV = 22;
  vec_t vec [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic stall, input logic bv, input logic br,
                       input logic [31:0] bpc, input logic [31:0] boff,
                       input logic jmp, input logic [25:0] jt);
    Stall_in = stall; BranchValid_in = bv; Branch_in = br;
    BranchPC_in = bpc; BranchOffset_in = boff; Jump_in = jmp; JumpTarget_in = jt;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //          stall bv br bpc           boff          jmp jt          fif fid pc            mis
    vec[0]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,26'h0,       1'b0,1'b0,32'h0000000C,1'b0};
    vec[1]  = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,26'h0,       1'b0,1'b0,32'h0000000C,1'b0};
    vec[2]  = '{1'b0,1'b1,1'b0,32'h10,       32'h7,        1'b0,26'h0,       1'b0,1'b0,32'h00000010,1'b0};
    vec[3]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,26'h40,      1'b1,1'b0,32'h00000100,1'b0};
    vec[4]  = '{1'b1,1'b1,1'b1,32'h500,      32'h4,        1'b1,26'h123,     1'b0,1'b0,32'h00000100,1'b0};
    vec[5]  = '{1'b0,1'b1,1'b1,32'h100,      32'hFFFFFFFF, 1'b0,26'h0,       1'b1,1'b1,32'h000000FC,1'b0};
    vec[6]  = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,26'h0,       1'b0,1'b0,32'h00000100,1'b0};
    vec[7]  = '{1'b1,1'b1,1'b1,32'h200,      32'h4,        1'b1,26'h3FF,     1'b1,1'b1,32'h00000210,1'b0};
    vec[8]  = '{1'b0,1'b1,1'b1,32'h800,      32'h0,        1'b0,26'h0,       1'b0,1'b0,32'h00000214,1'b0};
    vec[9]  = '{1'b0,1'b1,1'b1,32'hFFFFFFFC, 32'h2,        1'b0,26'h0,       1'b1,1'b1,32'h00000004,1'b0};
    vec[10] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,26'h0,       1'b0,1'b0,32'h00000008,1'b0};
    vec[11] = '{1'b0,1'b1,1'b1,32'h00400000, 32'h0,        1'b0,26'h0,       1'b1,1'b1,32'h00400000,1'b0};
    vec[12] = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,26'h0,       1'b0,1'b0,32'h00400000,1'b0};
    vec[13] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,26'h40,      1'b1,1'b0,32'h00000100,1'b0};
    vec[14] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,26'h0,       1'b0,1'b0,32'h00000104,1'b0};
    vec[15] = '{1'b0,1'b1,1'b1,32'hA0000000, 32'h0,        1'b0,26'h0,       1'b1,1'b1,32'hA0000000,1'b0};
    vec[16] = '{1'b1,1'b0,1'b0,32'h0,        32'h0,        1'b0,26'h0,       1'b0,1'b0,32'hA0000000,1'b0};
    vec[17] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b1,26'h3FFFFFF, 1'b1,1'b0,32'hAFFFFFFC,1'b0};
    vec[18] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,26'h0,       1'b0,1'b0,32'hB0000000,1'b0};
    vec[19] = '{1'b0,1'b1,1'b1,32'h102,      32'h0,        1'b0,26'h0,       1'b1,1'b1,32'h00000102,1'b1};
    vec[20] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,26'h0,       1'b0,1'b0,32'h00000106,1'b1};
    vec[21] = '{1'b0,1'b0,1'b0,32'h0,        32'h0,        1'b0,26'h0,       1'b0,1'b0,32'h0000010A,1'b1};

    // Reset held for 3 cycles with a taken branch presented.
    Reset_in = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 1'b1, 26'h1);
    repeat (3) @(posedge Clk_in);
    #1;
    check("reset_pc", PC_out, 32'h0);
    check("reset_misalign", 32'(Misalign_out), 32'h0);
    check("reset_flush_if", 32'(FlushIF_out), 32'h0);
    check("reset_flush_id", 32'(FlushID_out), 32'h0);
    @(negedge Clk_in);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0);
    Reset_in = 1'b0;
    @(posedge Clk_in); #1;
    check("post_reset_pc4", PC_out, 32'h4);
    @(posedge Clk_in); #1;
    check("post_reset_pc8", PC_out, 32'h8);

    // Table vectors, applied back to back from PC=8.
    for (int i = 0; i < NV; i++) begin
      @(negedge Clk_in);
      drive(vec[i].stall, vec[i].bv, vec[i].br, vec[i].bpc, vec[i].boff, vec[i].jmp, vec[i].jt);
      #1;
      check($sformatf("v%0d_flush_if", i), 32'(FlushIF_out), 32'(vec[i].fif && !DS));
      check($sformatf("v%0d_flush_id", i), 32'(FlushID_out), 32'(vec[i].fid && !DS));
      @(posedge Clk_in); #1;
      check($sformatf("v%0d_pc", i), PC_out, vec[i].pc);
      check($sformatf("v%0d_pc4", i), PCPlus4_out, vec[i].pc + 32'd4);
      check($sformatf("v%0d_misalign", i), 32'(Misalign_out), 32'(vec[i].mis));
    end

    // Taken branch, then asynchronous reset in the middle of REDIR.
    @(negedge Clk_in);
    drive(1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 1'b0, 26'h0);
    @(posedge Clk_in); #1;
    check("redir_pc", PC_out, 32'h300);
    #1;
    Reset_in = 1'b1;
    #1;
    check("async_reset_pc", PC_out, 32'h0);
    check("async_reset_misalign", 32'(Misalign_out), 32'h0);
    check("async_reset_flush_if", 32'(FlushIF_out), 32'h0);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0);
    @(negedge Clk_in);
    Reset_in = 1'b0;
    @(posedge Clk_in); #1;
    check("abandon_redir_pc", PC_out, 32'h4);

    // First redirect after reset must be honoured (state is RUN).
    @(negedge Clk_in);
    drive(1'b0, 1'b1, 1'b1, 32'h400, 32'h1, 1'b0, 26'h0);
    #1;
    check("post_reset_flush_if", 32'(FlushIF_out), 32'(!DS));
    check("post_reset_flush_id", 32'(FlushID_out), 32'(!DS));
    @(posedge Clk_in); #1;
    check("post_reset_branch_pc", PC_out, 32'h404);
    @(negedge Clk_in);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 26'h0);
    @(posedge Clk_in); #1;
    check("post_reset_advance_pc", PC_out, 32'h408);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
